// File: rtl/bit_scan_sequencer.sv
// Scans a 16-word pattern memory and emits bit mem[i][i] for each visited index i.
// Uses a wrapping first..last range, optional looping and a valid/ready output handshake.
module bit_scan_sequencer #(
  parameter  int AW = 4,
  localparam int DW = 2 ** AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] cfg_first,
  input  logic [AW-1:0] cfg_last,
  input  logic          cfg_loop,
  input  logic          stop,
  input  logic          abort,
  output logic          mem_en,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic          bit_out,
  output logic          bit_valid,
  input  logic          bit_ready,
  output logic [AW-1:0] cur_idx,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPT,
    OUT,
    DONE
  } state_t;

  state_t        state;
  logic [AW-1:0] idx;
  logic [AW-1:0] first_q;
  logic [AW-1:0] last_q;
  logic          loop_q;
  logic [AW-1:0] next_idx;

  assign next_idx = idx + 1'b1;

  // Outputs are registered alongside the state, so each one is set on the edge
  // that enters the state in which it must be visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      first_q   <= '0;
      last_q    <= '0;
      loop_q    <= 1'b0;
      mem_en    <= 1'b0;
      mem_addr  <= '0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      cur_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != IDLE && abort) begin
        state     <= IDLE;
        mem_en    <= 1'b0;
        bit_valid <= 1'b0;
        busy      <= 1'b0;
      end else begin
        if (state != IDLE && stop) begin
          loop_q <= 1'b0;
        end
        case (state)
          IDLE: begin
            if (start) begin
              first_q  <= cfg_first;
              last_q   <= cfg_last;
              loop_q   <= cfg_loop;
              idx      <= cfg_first;
              mem_en   <= 1'b1;
              mem_addr <= cfg_first;
              busy     <= 1'b1;
              state    <= FETCH;
            end
          end
          FETCH: begin
            mem_en <= 1'b0;
            state  <= CAPT;
          end
          CAPT: begin
            bit_out   <= mem_rdata[idx];
            cur_idx   <= idx;
            bit_valid <= 1'b1;
            state     <= OUT;
          end
          OUT: begin
            // A stop arriving on the final transfer of a pass ends the scan now.
            if (bit_ready) begin
              bit_valid <= 1'b0;
              if (idx != last_q) begin
                idx      <= next_idx;
                mem_addr <= next_idx;
                mem_en   <= 1'b1;
                state    <= FETCH;
              end else if (loop_q && !stop) begin
                idx      <= first_q;
                mem_addr <= first_q;
                mem_en   <= 1'b1;
                state    <= FETCH;
              end else begin
                done  <= 1'b1;
                state <= DONE;
              end
            end
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/bit_scan_sequencer.md
Name: bit_scan_sequencer

Overview:
- Sequences a 16-word x 16-bit pattern memory and serializes one selected bit per word: for index i, fetches word mem[i], emits bit mem[i][i].
- Replaces the free-running BCD counter plus 16:1 bit-mux path with a controlled scan:
  - programmable first/last index, with wrap-around
  - one-shot or looping mode
  - valid/ready output handshake so the consumer can stall the scan.
- Sits between the pattern memory, which it drives, and a serial bit consumer.

Parameters:
- AW, 4, index/address width; word width DW = 2**AW (16).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin scan; sampled only in IDLE.
- cfg_first  in  AW  first index of scan, latched on accepted start.
- cfg_last  in  AW  last index of scan, latched on accepted start.
- cfg_loop  in  1  1 = restart at first after last; latched on accepted start.
- stop  in  1  clears latched loop; scan ends after current last index.
- abort  in  1  terminate scan immediately.
- mem_en  out  1  memory read enable.
- mem_addr  out  AW  memory read address.
- mem_rdata  in  DW  read data, valid exactly 1 cycle after mem_en.
- bit_out  out  1  serialized bit.
- bit_valid  out  1  bit_out valid.
- bit_ready  in  1  consumer accepts bit.
- cur_idx  out  AW  index of current/held bit.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at end of a non-looping scan.

Behaviour:
- Reset values: state IDLE; mem_en=0, mem_addr=0, bit_out=0, bit_valid=0, cur_idx=0, busy=0, done=0; latched cfg cleared.
- rst dominates every other input. Reset mid-scan returns all outputs to reset values at the next edge; the held bit is discarded.
- States: IDLE, FETCH, CAPT, OUT, DONE.
- IDLE:
  - start=1 latches cfg, sets idx=cfg_first, goes to FETCH.
  - start in any other state is ignored.
- FETCH:
  - mem_en=1, mem_addr=idx.
  - Always goes to CAPT.
- CAPT:
  - Registers bit_out <= mem_rdata[idx] and cur_idx <= idx.
  - Goes to OUT.
- OUT:
  - bit_valid=1; bit_out and cur_idx held stable until the handshake.
  - Transfer occurs on a cycle with bit_valid && bit_ready.
  - On transfer with idx != last: idx <= idx+1 mod 16, go to FETCH.
  - On transfer with idx == last and loop=1: idx <= first, go to FETCH.
  - On transfer with idx == last and loop=0: go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency:
  - start sampled at edge N gives mem_en=1 in cycle N+1 and bit_valid=1 in cycle N+3.
  - Each further bit takes a minimum 3 cycles after transfer (FETCH, CAPT, OUT); maximum throughput is 1 bit per 3 cycles.
- Range arithmetic:
  - Scan length = ((last - first) mod 16) + 1.
  - first == last gives a single bit.
  - first > last wraps 15 -> 0 (e.g. 14..1 visits 14, 15, 0, 1).
  - Indices are never compared with signed arithmetic.
- stop:
  - Clears the latched loop bit in any non-IDLE state; the current pass completes normally and ends with a done pulse.
  - stop with loop=0, or stop in IDLE, has no effect.
- abort:
  - In any non-IDLE state, next state is IDLE.
  - bit_valid drops the next cycle; no done pulse.
  - A bit not yet transferred is lost.
  - abort has priority over stop and over a simultaneous transfer.
- Simultaneous start+abort in IDLE: the scan starts (abort is meaningless in IDLE).
- busy is registered from state; it is 0 in IDLE only and is 1 during DONE.

Test Plan:
- Memory preload: mem[i] = 1<<i for i = 0-5 and 10-12, all other words 0.
- Full scan: first=0, last=15, loop=0, bit_ready tied 1 -> bits 1111110000111000 with cur_idx 0..15; one done pulse; first bit_valid 3 cycles after start; 48 cycles from start to last transfer.
- BCD range: first=0, last=9 -> bits 1111110000, then done; mem_addr never exceeds 9.
- Wrap: first=14, last=1 -> cur_idx 14, 15, 0, 1 with bits 0, 0, 1, 1; done pulses once.
- Backpressure: full scan with bit_ready low for 5 cycles on idx 3 -> bit_valid, bit_out=1 and cur_idx=3 held throughout; no mem_en while stalled; sequence unchanged.
- Loop/stop: first=10, last=12, loop=1 -> bits 111 repeated; stop asserted during the second pass at idx 11 -> pass completes at idx 12, done pulses, IDLE.
- Abort/reset: abort in CAPT of idx 4 -> IDLE next cycle, bit_valid=0, no done. Repeat with rst=1 during OUT -> all outputs at reset values next edge. A later start runs a clean scan.
